regfile_scoreboard: RTL and testbench

Parametrised register file with N read ports, one write port, optional same-cycle write-through bypass, and a per-register pending-write scoreboard. The scoreboard tracks in-flight writes from issue to writeback and flags read-after-write hazards to the ID-stage stall logic. It sits in the decode stage, written from WB and marked from ID at issue. It supersedes the fixed 2-read, negedge-read register file and can serve wider or deeper register sets.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rf_pend_counter.sv | 35 +++
 rtl/regfile_scoreboard.sv | 125 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file / pending-write scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PEND_W_DEF = 2;

  // Pending-write counter at the default width.
  typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

  // Hard-wired zero register: reads as 0, ignores writes, never pending.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/rf_pend_counter.sv
// Saturating up/down pending-write counter for one register.
// flush clears the count and wins over inc/dec; inc together with dec holds.
module rf_pend_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt
);

  logic [PEND_W-1:0] cnt_r;

  // Count outstanding writes; saturate at both ends so stray writebacks never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {PEND_W{1'b0}};
    end else if (flush) begin
      cnt_r <= {PEND_W{1'b0}};
    end else if (inc && !dec && (cnt_r != {PEND_W{1'b1}})) begin
      cnt_r <= cnt_r + PEND_W'(1);
    end else if (dec && !inc && (cnt_r != {PEND_W{1'b0}})) begin
      cnt_r <= cnt_r - PEND_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD combinational read ports, one write port and a
// per-register pending-write scoreboard that flags RAW hazards to ID.
// Optional feature: define RF_BYPASS_EN for same-cycle write-through on every
// read port, letting the last outstanding writeback resolve rd_busy in the
// writeback cycle itself.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     hazard,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [NREG];
  logic [PEND_W-1:0] cnt_s  [NREG];
  logic              wb_en_s;

  assign wb_en_s = wb_valid && (wb_addr != ADDR_W'(ZERO_REG));

  // Register storage; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en_s) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Register 0 has no counter and is never pending.
  assign cnt_s[0] = {PEND_W{1'b0}};

  // An issue to a register whose counter is saturated must stall in ID.
  always_comb begin
    if (issue_addr == ADDR_W'(ZERO_REG)) begin
      issue_ready = 1'b1;
    end else begin
      issue_ready = (cnt_s[issue_addr] != {PEND_W{1'b1}});
    end
  end

  for (genvar i = 1; i < NREG; i++) begin : g_pend
    logic inc_s;
    logic dec_s;

    assign inc_s = issue_valid && issue_ready && (issue_addr == ADDR_W'(i));
    assign dec_s = wb_valid && (wb_addr == ADDR_W'(i)) && (cnt_s[i] != {PEND_W{1'b0}});

    rf_pend_counter #(
      .PEND_W(PEND_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .inc  (inc_s),
      .dec  (dec_s),
      .cnt  (cnt_s[i])
    );
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              wb_hit_s;
    logic              resolved_s;
    logic              busy_s;

    assign addr_s   = rd_addr[k*ADDR_W +: ADDR_W];
    assign wb_hit_s = wb_valid && (wb_addr == addr_s);

    // Read mux: zero register, optional write-through, else stored value.
    always_comb begin
      if (addr_s == ADDR_W'(ZERO_REG)) begin
        data_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
      end else if (wb_hit_s) begin
        data_s = wb_data;
`endif
      end else begin
        data_s = regs_r[addr_s];
      end
    end

    // Busy while writes are outstanding, unless the final one is landing now and is forwarded.
    always_comb begin
`ifdef RF_BYPASS_EN
      resolved_s = wb_hit_s && (cnt_s[addr_s] == PEND_W'(1));
`else
      resolved_s = 1'b0;
`endif
      if (addr_s == ADDR_W'(ZERO_REG)) begin
        busy_s = 1'b0;
      end else begin
        busy_s = (cnt_s[addr_s] != {PEND_W{1'b0}}) && !resolved_s;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_s;
    assign rd_busy[k]                  = busy_s;
  end

  assign hazard = |(rd_busy & rd_valid);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
// Expectations follow the RF_BYPASS_EN setting of the build.
module tb_regfile_scoreboard;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_valid;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        hazard;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .hazard     (hazard),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .issue_ready(issue_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset       = 1'b0;
    rd_addr     = 10'd0;
    rd_valid    = 2'b00;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    wb_valid    = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    flush       = 1'b0;
  endtask

  // Advance past the next posedge; inputs then change well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr = {5'd5, 5'd0};
    rd_valid = 2'b11;
    issue_addr = 5'd5;
    #2;
    n_checks++;
    if (rd_data !== 64'd0) $display("FAIL reset_rd_data: got %h expected %h", rd_data, 64'd0);
    else n_pass++;
    n_checks++;
    if (hazard !== 1'b0 || rd_busy !== 2'b00) $display("FAIL reset_busy: got hazard=%b busy=%b expected 0/00", hazard, rd_busy);
    else n_pass++;
    n_checks++;
    if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b expected 1", issue_ready);
    else n_pass++;
  endtask

  task automatic test_write_read();
    idle();
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    wb_data  = 32'hDEADBEEF;
    rd_addr  = {5'd7, 5'd7};
    #2;
    n_checks++;
    if (rd_data[31:0] !== (BYP ? 32'hDEADBEEF : 32'd0))
      $display("FAIL wr_same_cycle: got %h expected %h", rd_data[31:0], (BYP ? 32'hDEADBEEF : 32'd0));
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL wr_next_cycle: got %h expected %h", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
    else n_pass++;
  endtask

  task automatic test_raw();
    idle();
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    tick();
    issue_valid = 1'b0;
    rd_addr  = {5'd0, 5'd3};
    rd_valid = 2'b00;
    #2;
    n_checks++;
    if (rd_busy !== 2'b01 || hazard !== 1'b0)
      $display("FAIL raw_unused_port: got busy=%b hazard=%b expected 01/0", rd_busy, hazard);
    else n_pass++;
    rd_valid = 2'b01;
    #1;
    n_checks++;
    if (hazard !== 1'b1) $display("FAIL raw_hazard: got %b expected 1", hazard);
    else n_pass++;
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    wb_data  = 32'h0000_0033;
    #2;
    n_checks++;
    if (hazard !== !BYP || rd_data[31:0] !== (BYP ? 32'h33 : 32'h0))
      $display("FAIL raw_wb_cycle: got hazard=%b data=%h expected %b/%h", hazard, rd_data[31:0], !BYP, (BYP ? 32'h33 : 32'h0));
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (hazard !== 1'b0 || rd_data[31:0] !== 32'h33)
      $display("FAIL raw_after_wb: got hazard=%b data=%h expected 0/00000033", hazard, rd_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    idle();
    rd_addr = {5'd0, 5'd4};
    issue_valid = 1'b1;
    issue_addr  = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (issue_ready !== 1'b1) $display("FAIL sat_ready_before_%0d: got %b expected 1", i, issue_ready);
      else n_pass++;
      tick();
    end
    #2;
    n_checks++;
    if (issue_ready !== 1'b0) $display("FAIL sat_ready_full: got %b expected 0", issue_ready);
    else n_pass++;
    issue_addr = 5'd5;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) $display("FAIL sat_other_ready: got %b expected 1", issue_ready);
    else n_pass++;
    issue_addr = 5'd4;
    tick();
    issue_valid = 1'b0;
    #2;
    n_checks++;
    if (issue_ready !== 1'b0 || rd_busy[0] !== 1'b1)
      $display("FAIL sat_fourth_ignored: got ready=%b busy=%b expected 0/1", issue_ready, rd_busy[0]);
    else n_pass++;
    wb_valid = 1'b1;
    wb_addr  = 5'd4;
    wb_data  = 32'h44;
    tick();
    tick();
    #2;
    n_checks++;
    if (rd_busy[0] !== !BYP) $display("FAIL sat_last_wb_cycle: got %b expected %b", rd_busy[0], !BYP);
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || issue_ready !== 1'b1)
      $display("FAIL sat_cleared: got busy=%b ready=%b expected 0/1", rd_busy[0], issue_ready);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    idle();
    rd_addr = {5'd0, 5'd9};
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = 32'h99;
    #2;
    n_checks++;
    if (rd_busy[0] !== !BYP) $display("FAIL simul_during: got %b expected %b", rd_busy[0], !BYP);
    else n_pass++;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h99)
      $display("FAIL simul_count_held: got busy=%b data=%h expected 1/00000099", rd_busy[0], rd_data[31:0]);
    else n_pass++;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_busy[0] !== 1'b0) $display("FAIL simul_final_wb: got %b expected 0", rd_busy[0]);
    else n_pass++;
    // Zero register: write and issue are both dropped.
    rd_addr = {5'd0, 5'd0};
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'h1234;
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    #2;
    n_checks++;
    if (rd_data[31:0] !== 32'd0 || issue_ready !== 1'b1)
      $display("FAIL zero_during: got data=%h ready=%b expected 0/1", rd_data[31:0], issue_ready);
    else n_pass++;
    tick();
    idle();
    #2;
    n_checks++;
    if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0)
      $display("FAIL zero_after: got data=%h busy=%b expected 0/0", rd_data[31:0], rd_busy[0]);
    else n_pass++;
  endtask

  task automatic test_flush_reset();
    idle();
    rd_addr = {5'd5, 5'd2};
    issue_valid = 1'b1;
    issue_addr  = 5'd2;
    tick();
    issue_addr = 5'd5;
    tick();
    tick();
    issue_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_busy !== 2'b11) $display("FAIL flush_pre_busy: got %b expected 11", rd_busy);
    else n_pass++;
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_addr  = 5'd2;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_busy !== 2'b00) $display("FAIL flush_cleared: got %b expected 00", rd_busy);
    else n_pass++;
    wb_valid = 1'b1;
    wb_addr  = 5'd2;
    wb_data  = 32'hAB;
    tick();
    wb_valid = 1'b0;
    issue_addr = 5'd2;
    #2;
    n_checks++;
    if (rd_data[31:0] !== 32'hAB || rd_busy !== 2'b00 || issue_ready !== 1'b1)
      $display("FAIL flush_late_wb: got data=%h busy=%b ready=%b expected 000000ab/00/1", rd_data[31:0], rd_busy, issue_ready);
    else n_pass++;
    // Reset with issues outstanding; the same-cycle writeback is discarded.
    rd_addr = {5'd7, 5'd6};
    issue_valid = 1'b1;
    issue_addr  = 5'd6;
    tick();
    tick();
    issue_valid = 1'b0;
    reset = 1'b1;
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    wb_data  = 32'h55;
    tick();
    reset = 1'b0;
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_busy !== 2'b00 || rd_data !== 64'd0)
      $display("FAIL reset_mid: got busy=%b data=%h expected 00/0", rd_busy, rd_data);
    else n_pass++;
    wb_valid = 1'b1;
    wb_addr  = 5'd6;
    wb_data  = 32'h66;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++;
    if (rd_data[31:0] !== 32'h66 || rd_busy[0] !== 1'b0 || issue_ready !== 1'b1)
      $display("FAIL reset_late_wb: got data=%h busy=%b ready=%b expected 00000066/0/1", rd_data[31:0], rd_busy[0], issue_ready);
    else n_pass++;
  endtask

  initial begin
    idle();
    tick();
    test_reset();
    test_write_read();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
